// File: rtl/alert_sequencer_pkg.sv
// alert_sequencer_pkg: shared state encodings, notify codes, default parameters and helpers
package alert_sequencer_pkg;
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_ALARM   = 3'd2,
        S_NOTIFY  = 3'd3,
        S_RETRY   = 3'd4,
        S_HOLD    = 3'd5,
        S_FAULT   = 3'd6,
        S_CLEAR   = 3'd7
    } state_e;
    localparam logic [2:0] CODE_TEST     = 3'b111;
    localparam logic [2:0] CODE_LOCKDOWN = 3'b100;
    localparam logic [2:0] CODE_EVAC     = 3'b010;
    localparam logic [2:0] CODE_GENERIC  = 3'b001;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_ACK_TIMEOUT     = 1000;
    localparam int DEF_MAX_RETRIES     = 3;
    localparam int DEF_CLEAR_HOLD      = 8;
    function automatic logic [2:0] pick_code(input logic test, input logic lock, input logic evac);
        return test ? CODE_TEST : lock ? CODE_LOCKDOWN : evac ? CODE_EVAC : CODE_GENERIC;
    endfunction
    function automatic logic siren_state(input state_e s);
        return s inside {S_ALARM, S_NOTIFY, S_RETRY, S_HOLD, S_FAULT};
    endfunction
endpackage

// File: rtl/alert_sequencer_timer.sv
// cycle_timer: 16-bit loadable down-counter that holds at zero
// Ports: clk, rst_n (async active-low), load_i/load_val_i (load), dec_i (count down), count_o, zero_o
module cycle_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        dec_i,
    output logic [15:0] count_o,
    output logic        zero_o
);
    logic [15:0] count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else if (load_i) count_q <= load_val_i;
        else if (dec_i && count_q != '0) count_q <= count_q - 16'd1;
    end
    assign count_o = count_q;
    assign zero_o  = count_q == '0;
endmodule

// File: rtl/alert_sequencer.sv
// alert_sequencer: debounces emergency classifications, drives siren and authority notification with retries
// Ports: clk, rst_n (async active-low); classifier inputs confirmedEmergency, nonSpecificEmergency,
// needEvacuation, lockdownNeeded, isSystemTest, isAllClear; notifyAck from dialer;
// outputs notifyReq, notifyCode, sirenOn, escalated, faultOut, allClearPulse, retryCount, state
module alert_sequencer import alert_sequencer_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
    parameter int CLEAR_HOLD      = DEF_CLEAR_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       confirmedEmergency,
    input  logic       nonSpecificEmergency,
    input  logic       needEvacuation,
    input  logic       lockdownNeeded,
    input  logic       isSystemTest,
    input  logic       isAllClear,
    input  logic       notifyAck,
    output logic       notifyReq,
    output logic [2:0] notifyCode,
    output logic       sirenOn,
    output logic       escalated,
    output logic       faultOut,
    output logic       allClearPulse,
    output logic [1:0] retryCount,
    output logic [2:0] state
);
    localparam logic [15:0] DEB_LD = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] ACK_LD = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] CLR_LD = 16'(CLEAR_HOLD - 1);
    state_e      state_q, state_d;
    logic [2:0]  code_q, code_d;
    logic [1:0]  retry_q, retry_d;
    logic        esc_q, esc_d, armed_q, t_load, t_dec, t_zero, escalate;
    logic [15:0] t_val, t_count;
    cycle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (armed_q & t_load),
        .load_val_i (t_val),
        .dec_i      (armed_q & t_dec),
        .count_o    (t_count),
        .zero_o     (t_zero)
    );
    // Re-notify only when the situation worsens from a non-lockdown code
    assign escalate = state_q == S_HOLD && lockdownNeeded && (code_q == CODE_EVAC || code_q == CODE_GENERIC);
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        retry_d = retry_q;
        esc_d   = esc_q;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = '0;
        case (state_q)
            S_IDLE:
                if (confirmedEmergency) state_d = S_ALARM;
                else if (nonSpecificEmergency) begin
                    state_d = S_QUALIFY;
                    t_load  = 1'b1;
                    t_val   = DEB_LD;
                end
            // The IDLE cycle counts as the first high cycle, so fire once the timer would hit zero
            S_QUALIFY:
                if (confirmedEmergency) state_d = S_ALARM;
                else if (!nonSpecificEmergency) state_d = S_IDLE;
                else if (t_count <= 16'd1) state_d = S_ALARM;
                else t_dec = 1'b1;
            S_ALARM: begin
                state_d = S_NOTIFY;
                retry_d = '0;
                t_load  = 1'b1;
                t_val   = ACK_LD;
            end
            S_NOTIFY:
                if (notifyAck) begin
                    state_d = S_HOLD;
                    t_load  = 1'b1;
                    t_val   = CLR_LD;
                end else if (t_zero) begin
                    state_d = S_RETRY;
                    retry_d = retry_q + 2'd1;
                end else t_dec = 1'b1;
            S_RETRY: begin
                state_d = 32'(retry_q) < MAX_RETRIES ? S_NOTIFY : S_FAULT;
                t_load  = 1'b1;
                t_val   = 32'(retry_q) < MAX_RETRIES ? ACK_LD : CLR_LD;
            end
            S_HOLD, S_FAULT:
                if (escalate) begin
                    esc_d   = 1'b1;
                    state_d = S_ALARM;
                end else if (!isAllClear) begin
                    t_load = 1'b1;
                    t_val  = CLR_LD;
                end else if (t_zero) state_d = S_CLEAR;
                else t_dec = 1'b1;
            S_CLEAR: begin
                state_d = S_IDLE;
                esc_d   = 1'b0;
                retry_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Code is captured on the cycle the alarm is raised, so ALARM already shows it
        if (state_d == S_ALARM) code_d = pick_code(isSystemTest, lockdownNeeded, needEvacuation);
    end
    // First edge after reset only arms the sequencer; decisions start on the second edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q       <= 1'b0;
            state_q       <= S_IDLE;
            code_q        <= '0;
            retry_q       <= '0;
            esc_q         <= 1'b0;
            notifyReq     <= 1'b0;
            sirenOn       <= 1'b0;
            faultOut      <= 1'b0;
            allClearPulse <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (armed_q) begin
                state_q       <= state_d;
                code_q        <= code_d;
                retry_q       <= retry_d;
                esc_q         <= esc_d;
                notifyReq     <= state_d == S_NOTIFY;
                sirenOn       <= siren_state(state_d) && code_d != CODE_TEST;
                faultOut      <= state_d == S_FAULT;
                allClearPulse <= state_d == S_CLEAR;
            end
        end
    end
    assign notifyCode = code_q;
    assign retryCount = retry_q;
    assign escalated  = esc_q;
    assign state      = state_q;
endmodule

// File: tb/tb_alert_sequencer.sv
// tb_alert_sequencer: table vectors, directed corner sequences and randomized run against a behavioural model
module tb_alert_sequencer;
    localparam int DEB = 4, ACKT = 10, MAXR = 3, CLRH = 8;
    localparam logic [6:0] CONF = 7'b1000000, NSE = 7'b0100000, EVAC = 7'b0010000, LOCK = 7'b0001000;
    localparam logic [6:0] TEST = 7'b0000100, CLR = 7'b0000010, ACK = 7'b0000001, NONE = 7'b0;
    logic clk = 1'b0, rst_n = 1'b0;
    logic confirmedEmergency = 0, nonSpecificEmergency = 0, needEvacuation = 0, lockdownNeeded = 0;
    logic isSystemTest = 0, isAllClear = 0, notifyAck = 0;
    logic notifyReq, sirenOn, escalated, faultOut, allClearPulse;
    logic [2:0] notifyCode, state;
    logic [1:0] retryCount;
    logic [12:0] outs;
    int vectors = 0, miscompares = 0;
    int m_state, m_code, m_retry, m_esc, m_hi, m_wait, m_clr;
    bit m_armed;
    typedef struct packed { logic [6:0] in; logic [12:0] exp; } vec_t;
    vec_t tv [21];

    alert_sequencer #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ACKT), .MAX_RETRIES(MAXR), .CLEAR_HOLD(CLRH)) dut (
        .clk(clk), .rst_n(rst_n),
        .confirmedEmergency(confirmedEmergency), .nonSpecificEmergency(nonSpecificEmergency),
        .needEvacuation(needEvacuation), .lockdownNeeded(lockdownNeeded), .isSystemTest(isSystemTest),
        .isAllClear(isAllClear), .notifyAck(notifyAck),
        .notifyReq(notifyReq), .notifyCode(notifyCode), .sirenOn(sirenOn), .escalated(escalated),
        .faultOut(faultOut), .allClearPulse(allClearPulse), .retryCount(retryCount), .state(state)
    );
    always #5 clk = ~clk;
    assign outs = {notifyReq, notifyCode, sirenOn, escalated, faultOut, allClearPulse, retryCount, state};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_code = 0; m_retry = 0; m_esc = 0; m_hi = 0; m_wait = 0; m_clr = 0; m_armed = 0;
    endfunction

    function automatic void go_alarm(input logic [6:0] in);
        m_state = 2;
        m_code = in[2] ? 7 : in[3] ? 4 : in[4] ? 2 : 1;
    endfunction

    function automatic void clear_step(input logic k);
        m_clr = k ? m_clr + 1 : 0;
        if (m_clr == CLRH) m_state = 7;
    endfunction

    // Behaviour stated in terms of elapsed high/wait cycles rather than a down-counter
    function automatic void model_step(input logic [6:0] in);
        if (!m_armed) begin
            m_armed = 1;
            return;
        end
        case (m_state)
            0: if (in[6]) go_alarm(in); else if (in[5]) begin m_hi = 1; m_state = 1; end
            1: if (in[6]) go_alarm(in);
               else if (!in[5]) m_state = 0;
               else begin m_hi++; if (m_hi >= DEB) go_alarm(in); end
            2: begin m_state = 3; m_retry = 0; m_wait = 0; end
            3: if (in[0]) begin m_state = 5; m_clr = 0; end
               else begin m_wait++; if (m_wait == ACKT) begin m_state = 4; m_retry++; end end
            4: if (m_retry < MAXR) begin m_state = 3; m_wait = 0; end else begin m_state = 6; m_clr = 0; end
            5: if (in[3] && (m_code == 2 || m_code == 1)) begin m_esc = 1; go_alarm(in); end else clear_step(in[1]);
            6: clear_step(in[1]);
            default: begin m_state = 0; m_esc = 0; m_retry = 0; end
        endcase
    endfunction

    function automatic logic [12:0] model_outs();
        logic siren;
        siren = m_state >= 2 && m_state <= 6 && m_code != 7;
        return {m_state == 3, 3'(m_code), siren, m_esc[0], m_state == 6, m_state == 7, 2'(m_retry), 3'(m_state)};
    endfunction

    task automatic cycle(input logic [6:0] in);
        {confirmedEmergency, nonSpecificEmergency, needEvacuation, lockdownNeeded, isSystemTest, isAllClear, notifyAck} = in;
        @(posedge clk);
        model_step(in);
        #1;
        check("model", 16'(outs), 16'(model_outs()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {confirmedEmergency, nonSpecificEmergency, needEvacuation, lockdownNeeded, isSystemTest, isAllClear, notifyAck} = NONE;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 16'(outs), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] rin;
        logic nse_lvl, clr_lvl;
        int drops, pulses;
        int seen[$];
        for (int i = 0; i < 3; i++) tv[i] = '{NSE, 13'b0_000_0_0_0_0_00_001};
        tv[3] = '{NONE, 13'b0_000_0_0_0_0_00_000};
        for (int i = 4; i < 7; i++) tv[i] = '{NSE, 13'b0_000_0_0_0_0_00_001};
        tv[7] = '{NSE,  13'b0_001_1_0_0_0_00_010};
        tv[8] = '{NONE, 13'b1_001_1_0_0_0_00_011};
        tv[9] = '{ACK,  13'b0_001_1_0_0_0_00_101};
        for (int i = 10; i < 17; i++) tv[i] = '{CLR, 13'b0_001_1_0_0_0_00_101};
        tv[17] = '{CLR,  13'b0_001_0_0_0_1_00_111};
        tv[18] = '{NONE, 13'b0_001_0_0_0_0_00_000};
        tv[19] = '{ACK,  13'b0_001_0_0_0_0_00_000};
        tv[20] = '{CLR,  13'b0_001_0_0_0_0_00_000};

        // Debounce: 3 high cycles then low must not alarm; 4 high must; then ack and clear
        do_reset();
        cycle(NONE);
        for (int i = 0; i < 21; i++) begin
            cycle(tv[i].in);
            check($sformatf("table[%0d]", i), 16'(outs), 16'(tv[i].exp));
        end

        // First edge after reset release is ignored; ack on 5th NOTIFY cycle with lockdown code
        do_reset();
        cycle(CONF | LOCK);
        check("first_edge_idle", 16'(state), 16'd0);
        cycle(CONF | LOCK);
        check("lock_alarm_state", 16'(state), 16'd2);
        check("lock_alarm_code", 16'(notifyCode), 16'd4);
        cycle(NONE);
        repeat (4) cycle(NONE);
        check("notify_cycle4", 16'(notifyReq), 16'd1);
        cycle(ACK);
        check("ack_hold_state", 16'(state), 16'd5);
        check("ack_hold_code", 16'(notifyCode), 16'd4);
        check("ack_hold_siren", 16'(sirenOn), 16'd1);
        check("ack_hold_retry", 16'(retryCount), 16'd0);

        // No ack: three retries then fault; fault cleared only through CLEAR
        do_reset();
        cycle(NONE);
        cycle(CONF | EVAC);
        check("evac_code", 16'(notifyCode), 16'd2);
        drops = 0;
        seen.delete();
        for (int i = 0; i < 80 && state != 3'd6; i++) begin
            cycle(ACK & 7'b0);
            if (state == 3'd4 && !notifyReq) begin drops++; seen.push_back(int'(retryCount)); end
        end
        check("fault_reached", 16'(state), 16'd6);
        check("retry_drops", 16'(drops), 16'd3);
        for (int i = 0; i < seen.size(); i++) check($sformatf("retry_seen[%0d]", i), 16'(seen[i]), 16'(i + 1));
        check("fault_out", 16'(faultOut), 16'd1);
        check("fault_siren", 16'(sirenOn), 16'd1);
        check("fault_req", 16'(notifyReq), 16'd0);
        repeat (7) cycle(CLR);
        check("fault_held", 16'(faultOut), 16'd1);
        cycle(CLR);
        check("fault_to_clear", 16'(state), 16'd7);
        check("fault_cleared", 16'(faultOut), 16'd0);

        // Escalation from evacuation to lockdown, then interrupted all-clear
        do_reset();
        cycle(NONE);
        cycle(CONF | EVAC);
        cycle(NONE);
        cycle(ACK);
        check("evac_hold", 16'(state), 16'd5);
        cycle(LOCK);
        check("esc_state", 16'(state), 16'd2);
        check("esc_flag", 16'(escalated), 16'd1);
        check("esc_code", 16'(notifyCode), 16'd4);
        cycle(NONE);
        cycle(ACK);
        check("esc_hold", 16'(state), 16'd5);
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(i == 7 || i == 16 ? NONE : CLR);
            if (allClearPulse) pulses++;
        end
        check("clear_pulses", 16'(pulses), 16'd1);
        check("clear_idle", 16'(state), 16'd0);
        check("clear_esc", 16'(escalated), 16'd0);

        // System test suppresses the siren; async reset mid-handshake
        do_reset();
        cycle(NONE);
        cycle(CONF | TEST | LOCK);
        check("test_code", 16'(notifyCode), 16'd7);
        check("test_siren_alarm", 16'(sirenOn), 16'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(NONE);
            check("test_siren_notify", 16'({sirenOn, notifyReq}), 16'b01);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 16'(outs), 16'd0);
        model_reset();

        // Randomized run against the model
        do_reset();
        nse_lvl = 0;
        clr_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            if ($urandom_range(0, 5) == 0) nse_lvl = ~nse_lvl;
            if ($urandom_range(0, 11) == 0) clr_lvl = ~clr_lvl;
            rin = {$urandom_range(0, 59) == 0, nse_lvl, 1'($urandom), $urandom_range(0, 9) == 0,
                   $urandom_range(0, 15) == 0, clr_lvl, $urandom_range(0, 7) == 0};
            cycle(rin);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
